// File: rtl/isa_pkg.sv
// isa_pkg: IR field layout, opcode values and fetch FSM state type.
// Also holds a helper that assembles an IR word from its fields.
package isa_pkg;

  localparam int IR_W = 32;

  localparam int OP_MSB   = 31;
  localparam int OP_LSB   = 27;
  localparam int DRG_MSB  = 26;
  localparam int DRG_LSB  = 22;
  localparam int SRG1_MSB = 21;
  localparam int SRG1_LSB = 17;
  localparam int MODE_MSB = 16;
  localparam int MODE_LSB = 16;
  localparam int SRG2_MSB = 15;
  localparam int SRG2_LSB = 11;
  localparam int IMM_MSB  = 10;
  localparam int IMM_LSB  = 0;

  localparam logic [4:0] OP_MOVSGPR = 5'd0;
  localparam logic [4:0] OP_MOV     = 5'd1;
  localparam logic [4:0] OP_ADD     = 5'd2;
  localparam logic [4:0] OP_SUB     = 5'd3;
  localparam logic [4:0] OP_MUL     = 5'd4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } fetch_state_e;

  function automatic logic [IR_W-1:0] mk_ir(input logic [4:0]  op,
                                            input logic [4:0]  drg,
                                            input logic [4:0]  srg1,
                                            input logic        mode,
                                            input logic [4:0]  srg2,
                                            input logic [10:0] imm);
    logic [IR_W-1:0] w;
    w = '0;
    w[OP_MSB:OP_LSB]     = op;
    w[DRG_MSB:DRG_LSB]   = drg;
    w[SRG1_MSB:SRG1_LSB] = srg1;
    w[MODE_MSB:MODE_LSB] = mode;
    w[SRG2_MSB:SRG2_LSB] = srg2;
    w[IMM_MSB:IMM_LSB]   = imm;
    return w;
  endfunction

endpackage

// File: rtl/fetch_buf.sv
// fetch_buf: 2-entry FIFO holding {pc, instruction} pairs between memory and execute.
// Flush empties it in one cycle and wins over a same-cycle push.
module fetch_buf #(
  parameter int W = 40
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic [1:0]   count
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;

  assign rdata = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: walks the PC through a sync-read instruction memory and hands IR words to execute.
// Defining FETCH_REDIRECT_EN adds redir_valid/redir_addr with epoch-tagged discard of the in-flight read.
//
// state   | meaning
// S_IDLE  | waiting for start
// S_FETCH | issuing reads, PC advancing toward last_addr
// S_DRAIN | last read issued, waiting for buffered words to be accepted
// S_DONE  | last word accepted, done pulse, back to idle
module instr_fetch #(
  parameter int ADDR_W = 8,
  parameter int IR_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] last_addr,
  output logic              imem_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [IR_W-1:0]   imem_rdata,
  output logic              ir_valid,
  input  logic              ir_ready,
  output logic [IR_W-1:0]   ir,
  output logic [ADDR_W-1:0] ir_pc,
  output logic              busy,
  output logic              done
`ifdef FETCH_REDIRECT_EN
  ,
  input  logic              redir_valid,
  input  logic [ADDR_W-1:0] redir_addr
`endif
);

  import isa_pkg::*;

  localparam int BUF_W = ADDR_W + IR_W;

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, last_q, rd_pc_q;
  logic              inflight_q;
  logic              issue, push, pop, redir, start_ok;
  logic [1:0]        count;
  logic [2:0]        occupancy;
  logic [BUF_W-1:0]  buf_rdata;

`ifdef FETCH_REDIRECT_EN
  logic epoch_q, rd_epoch_q;
  assign redir = redir_valid && (state_q == S_FETCH || state_q == S_DRAIN);
  assign push  = inflight_q && (rd_epoch_q == epoch_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      epoch_q    <= 1'b0;
      rd_epoch_q <= 1'b0;
    end else begin
      if (redir) epoch_q <= ~epoch_q;
      if (issue) rd_epoch_q <= epoch_q;
    end
  end
`else
  assign redir = 1'b0;
  assign push  = inflight_q;
`endif

  assign ir_valid  = (count != 2'd0);
  assign pop       = ir_valid && ir_ready;
  assign start_ok  = start && (state_q == S_IDLE || state_q == S_DONE);
  assign imem_addr = pc_q;
  assign {ir_pc, ir} = buf_rdata;

  // In-flight read counts as occupied so a response always finds a free slot.
  assign occupancy = {1'b0, count} + {2'b00, inflight_q};
  assign issue     = (state_q == S_FETCH) && !redir && (occupancy < (3'd2 + {2'b00, pop}));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= '0;
      last_q     <= '0;
      rd_pc_q    <= '0;
      inflight_q <= 1'b0;
    end else begin
      if (start_ok) begin
        pc_q   <= start_addr;
        last_q <= last_addr;
      end else if (redir) begin
`ifdef FETCH_REDIRECT_EN
        pc_q <= redir_addr;
`endif
      end else if (issue) begin
        pc_q <= pc_q + 1'b1;
      end
      if (issue) rd_pc_q <= pc_q;
      inflight_q <= issue;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_ok) state_d = S_FETCH;
      S_FETCH: begin
        if (redir)                              state_d = S_FETCH;
        else if (issue && (pc_q == last_q))     state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (redir)                                              state_d = S_FETCH;
        else if (pop && (count == 2'd1) && !inflight_q)         state_d = S_DONE;
      end
      S_DONE:  state_d = start_ok ? S_FETCH : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    imem_en = issue;
    busy    = (state_q == S_FETCH) || (state_q == S_DRAIN);
    done    = (state_q == S_DONE);
  end

  fetch_buf #(.W(BUF_W)) u_buf (
    .clk   (clk),
    .rst   (rst),
    .flush (redir),
    .push  (push),
    .wdata ({rd_pc_q, imem_rdata}),
    .pop   (pop),
    .rdata (buf_rdata),
    .count (count)
  );

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed runs against instr_fetch with a sync-read memory model and acceptance log.
// Redirect scenario is compiled in when FETCH_REDIRECT_EN is defined.
module tb_instr_fetch;
  import isa_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  start_addr, last_addr;
  logic        imem_en;
  logic [7:0]  imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        ir_valid, ir_ready;
  logic [31:0] ir;
  logic [7:0]  ir_pc;
  logic        busy, done;
`ifdef FETCH_REDIRECT_EN
  logic        redir_valid = 1'b0;
  logic [7:0]  redir_addr = '0;
`endif

  instr_fetch #(.ADDR_W(8), .IR_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .start_addr (start_addr),
    .last_addr  (last_addr),
    .imem_en    (imem_en),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .ir_valid   (ir_valid),
    .ir_ready   (ir_ready),
    .ir         (ir),
    .ir_pc      (ir_pc),
    .busy       (busy),
    .done       (done)
`ifdef FETCH_REDIRECT_EN
    ,
    .redir_valid(redir_valid),
    .redir_addr (redir_addr)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input logic [7:0] a);
    logic [4:0] op;
    case (a % 8'd5)
      8'd0:    op = OP_MOVSGPR;
      8'd1:    op = OP_MOV;
      8'd2:    op = OP_ADD;
      8'd3:    op = OP_SUB;
      default: op = OP_MUL;
    endcase
    return mk_ir(op, a[4:0], a[7:3], a[0], ~a[4:0], {3'b000, a});
  endfunction

  logic [31:0] mem [256];
  initial for (int i = 0; i < 256; i++) mem[i] = exp_word(8'(i));

  always @(posedge clk) if (imem_en) imem_rdata <= mem[imem_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0]  acc_pc[$];
  logic [31:0] acc_ir[$];
  int          acc_cyc[$];
  int          done_cnt = 0;
  bit          mon_ovr = 1'b0;
  int          n_iss = 0, n_acc = 0;
  bit          prev_stall = 1'b0;
  logic [7:0]  prev_pc;
  logic [31:0] prev_ir;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        check_val("stall_hold", 64'({ir_valid, ir_pc, ir}), 64'({1'b1, prev_pc, prev_ir}));
      if (done) done_cnt++;
      if (mon_ovr) begin
        if (imem_en)
          check_val("issue_room", 64'((n_iss - n_acc - int'(ir_valid && ir_ready)) < 2), 64'(1));
        if (imem_en) n_iss++;
        if (ir_valid && ir_ready) n_acc++;
      end
      if (ir_valid && ir_ready) begin
        acc_pc.push_back(ir_pc);
        acc_ir.push_back(ir);
        acc_cyc.push_back(cyc);
      end
      prev_stall = ir_valid && !ir_ready;
      prev_pc    = ir_pc;
      prev_ir    = ir;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    acc_pc.delete();
    acc_ir.delete();
    acc_cyc.delete();
  endtask

  task automatic do_start(input logic [7:0] s, input logic [7:0] l);
    start      = 1'b1;
    start_addr = s;
    last_addr  = l;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget, input bit toggle);
    int n  = 0;
    int d0 = done_cnt;
    int pat[4] = '{1, 0, 0, 1};
    while (done_cnt == d0 && n < budget) begin
      if (toggle) ir_ready = (pat[(n + 1) % 4] != 0);
      tick();
      n++;
    end
    check_val(tag, 64'(done_cnt != d0), 64'(1));
    ir_ready = 1'b1;
  endtask

  task automatic check_seq(input string tag, input logic [7:0] first, input int n);
    logic [7:0] p;
    check_val({tag, "_count"}, 64'(acc_pc.size()), 64'(n));
    for (int i = 0; i < n; i++) begin
      if (i < acc_pc.size()) begin
        p = first + 8'(i);
        check_val({tag, "_pc"}, 64'(acc_pc[i]), 64'(p));
        check_val({tag, "_ir"}, 64'(acc_ir[i]), 64'(exp_word(p)));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int d0;
    rst = 1'b1; start = 1'b0; start_addr = '0; last_addr = '0; ir_ready = 1'b0;
    repeat (2) tick();
    check_val("rst_imem_en",   64'(imem_en),   64'(0));
    check_val("rst_imem_addr", 64'(imem_addr), 64'(0));
    check_val("rst_ir_valid",  64'(ir_valid),  64'(0));
    check_val("rst_ir",        64'(ir),        64'(0));
    check_val("rst_ir_pc",     64'(ir_pc),     64'(0));
    check_val("rst_busy",      64'(busy),      64'(0));
    check_val("rst_done",      64'(done),      64'(0));
    rst = 1'b0;
    tick();

    // Run 1: 0x10..0x13, ready held high
    clear_log();
    ir_ready = 1'b1;
    d0 = done_cnt;
    do_start(8'h10, 8'h13);
    check_val("r1_busy",      64'(busy),     64'(1));
    check_val("r1_valid_c0",  64'(ir_valid), 64'(0));
    tick();
    check_val("r1_valid_c1",  64'(ir_valid), 64'(0));
    tick();
    check_val("r1_valid_c2",  64'(ir_valid), 64'(1));
    check_val("r1_first_pc",  64'(ir_pc),    64'(8'h10));
    wait_done("r1_done_seen", 20, 1'b0);
    repeat (2) tick();
    check_val("r1_done_once", 64'(done_cnt - d0), 64'(1));
    check_val("r1_idle",      64'(busy),          64'(0));
    check_seq("r1", 8'h10, 4);
    for (int i = 1; i < acc_cyc.size(); i++)
      check_val("r1_back_to_back", 64'(acc_cyc[i] - acc_cyc[0]), 64'(i));

    // Run 2: same range, ready toggling 1,0,0,1
    clear_log();
    n_iss = 0; n_acc = 0; mon_ovr = 1'b1;
    d0 = done_cnt;
    ir_ready = 1'b1;
    do_start(8'h10, 8'h13);
    wait_done("r2_done_seen", 40, 1'b1);
    repeat (2) tick();
    mon_ovr = 1'b0;
    check_val("r2_done_once", 64'(done_cnt - d0), 64'(1));
    check_seq("r2", 8'h10, 4);

    // Run 3: wrap through 0xFF -> 0x00
    clear_log();
    do_start(8'hFE, 8'h01);
    wait_done("r3_done_seen", 20, 1'b0);
    tick();
    check_seq("r3", 8'hFE, 4);

    // Run 4: single instruction, second start while busy ignored
    clear_log();
    d0 = done_cnt;
    do_start(8'h05, 8'h05);
    do_start(8'h20, 8'h25);
    wait_done("r4_done_seen", 20, 1'b0);
    repeat (4) tick();
    check_val("r4_done_once", 64'(done_cnt - d0), 64'(1));
    check_val("r4_idle",      64'(busy),          64'(0));
    check_seq("r4", 8'h05, 1);

    // Run 5: reset with two words buffered, then a normal run
    clear_log();
    ir_ready = 1'b0;
    do_start(8'h10, 8'h13);
    repeat (3) tick();
    check_val("r5_pre_valid", 64'(ir_valid), 64'(1));
    check_val("r5_pre_pc",    64'(ir_pc),    64'(8'h10));
    check_val("r5_no_issue",  64'(imem_en),  64'(0));
    rst = 1'b1;
    #1;
    check_val("r5_rst_valid", 64'(ir_valid), 64'(0));
    check_val("r5_rst_busy",  64'(busy),     64'(0));
    check_val("r5_rst_en",    64'(imem_en),  64'(0));
    tick();
    rst = 1'b0;
    tick();
    clear_log();
    ir_ready = 1'b1;
    do_start(8'h30, 8'h31);
    wait_done("r5_done_seen", 20, 1'b0);
    tick();
    check_seq("r5", 8'h30, 2);

`ifdef FETCH_REDIRECT_EN
    // Run 6: redirect to 0x40 while the read of 0x12 is in flight
    clear_log();
    ir_ready = 1'b1;
    do_start(8'h10, 8'h1F);
    repeat (3) tick();
    redir_valid = 1'b1;
    redir_addr  = 8'h40;
    tick();
    redir_valid = 1'b0;
    check_val("r6_flush_c0", 64'(ir_valid), 64'(0));
    tick();
    check_val("r6_flush_c1", 64'(ir_valid), 64'(0));
    tick();
    check_val("r6_new_valid", 64'(ir_valid), 64'(1));
    check_val("r6_new_pc",    64'(ir_pc),    64'(8'h40));
    tick();
    check_val("r6_count", 64'(acc_pc.size()), 64'(3));
    if (acc_pc.size() >= 3) begin
      check_val("r6_pc0", 64'(acc_pc[0]), 64'(8'h10));
      check_val("r6_pc1", 64'(acc_pc[1]), 64'(8'h11));
      check_val("r6_pc2", 64'(acc_pc[2]), 64'(8'h40));
      check_val("r6_ir2", 64'(acc_ir[2]), 64'(exp_word(8'h40)));
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
